// File: rtl/seq_decoder_pkg.sv
// Shared definitions for the sequential one-hot decoder family.
//   state_t       : FSM state encoding (IDLE, DRIVE, GAP, ERR)
//   cnt_width()   : width of the pulse/gap down-counter
//   params_legal(): parameter legality predicate, checked at elaboration
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Counter must hold max(pulse_len, gap_len); never narrower than 1 bit.
  function automatic int cnt_width(input int pulse_len, input int gap_len);
    int m;
    m = (pulse_len > gap_len) ? pulse_len : gap_len;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic bit params_legal(input int code_w, input int num_out,
                                      input int pulse_len, input int gap_len);
    return (code_w >= 1) && (code_w <= 30) &&
           (num_out >= 2) && (num_out <= (1 << code_w)) &&
           (pulse_len >= 1) && (gap_len >= 0);
  endfunction

endpackage

// File: rtl/binary_to_onehot.sv
// Combinational binary-to-one-hot decoder.
//   code     : binary input code
//   onehot   : NUM_OUT lines, bit [code] set when code is in range, else all zero
//   in_range : high when code < NUM_OUT
module binary_to_onehot #(
  parameter int CODE_W  = 4,
  parameter int NUM_OUT = 10
) (
  input  logic [CODE_W-1:0]  code,
  output logic [NUM_OUT-1:0] onehot,
  output logic               in_range
);

  localparam int unsigned NUM_OUT_U = NUM_OUT;

  logic [31:0] code_ext;

  assign code_ext = 32'(code);
  assign in_range = (code_ext < NUM_OUT_U);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_OUT_U; i++) begin
      onehot[i] = (code_ext == i);
    end
  end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Sequential one-hot decoder: accepts a binary code over valid/ready, drives the
// matching output line for PULSE_LEN cycles, then idles GAP_LEN cycles before
// the next accept. Codes >= NUM_OUT give a one-cycle err pulse and no line.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : code offered
//   in_ready  : block can accept (IDLE and not in reset), combinational
//   in_code   : binary code, sampled only on handshake
//   out       : registered one-hot lines
//   out_valid : high while a line is driven
//   err       : one-cycle pulse on an invalid code
//   code_q    : last accepted code
//   busy      : high in any state other than IDLE
module seq_onehot_decoder
  import seq_decoder_pkg::*;
#(
  parameter int CODE_W    = 4,
  parameter int NUM_OUT   = 10,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  in_code,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid,
  output logic               err,
  output logic [CODE_W-1:0]  code_q,
  output logic               busy
);

  localparam int CNT_W = cnt_width(PULSE_LEN, GAP_LEN);

  if (!params_legal(CODE_W, NUM_OUT, PULSE_LEN, GAP_LEN)) begin : g_param_check
    $error("seq_onehot_decoder: illegal parameter set");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OUT-1:0] out_d;
  logic               err_d;
  logic [CODE_W-1:0]  code_d;
  logic [NUM_OUT-1:0] dec_lines;
  logic               dec_in_range;
  logic               accept;

  binary_to_onehot #(
    .CODE_W (CODE_W),
    .NUM_OUT(NUM_OUT)
  ) u_dec (
    .code    (in_code),
    .onehot  (dec_lines),
    .in_range(dec_in_range)
  );

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = |out;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out;
    err_d   = 1'b0;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        // Decoder result is only consumed under accept, so an unknown
        // in_code while in_valid is low never reaches out or err.
        if (accept) begin
          code_d = in_code;
          if (dec_in_range) begin
            out_d   = dec_lines;
            cnt_d   = CNT_W'(PULSE_LEN - 1);
            state_d = DRIVE;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          out_d = '0;
          if (GAP_LEN == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = CNT_W'(GAP_LEN - 1);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out     <= '0;
      err     <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
      err     <= err_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Testbench for seq_onehot_decoder: a default instance (P=3, G=2) and a fast
// instance (P=1, G=0) share the same inputs. A reference model tracks, per
// instance, the edge of the last accept and its code; every expected output is
// derived from the elapsed edge count since that accept.
module tb_seq_onehot_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_code = 4'd0;

  logic       rdy0, ov0, err0, busy0;
  logic [9:0] out0;
  logic [3:0] cq0;
  logic       rdy1, ov1, err1, busy1;
  logic [9:0] out1;
  logic [3:0] cq1;

  always #5 clk = ~clk;

  seq_onehot_decoder #(
    .CODE_W(4), .NUM_OUT(10), .PULSE_LEN(3), .GAP_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_code(in_code), .out(out0), .out_valid(ov0), .err(err0),
    .code_q(cq0), .busy(busy0)
  );

  seq_onehot_decoder #(
    .CODE_W(4), .NUM_OUT(10), .PULSE_LEN(1), .GAP_LEN(0)
  ) dut_fast (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_code(in_code), .out(out1), .out_valid(ov1), .err(err1),
    .code_q(cq1), .busy(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int plen[2] = '{3, 1};
  int glen[2] = '{2, 0};
  int n_edge  = 0;
  int acc_edge[2];
  int acc_code[2];
  bit have[2];
  bit known = 1'b0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  // Cycles from an accept until the next accept is possible.
  function automatic int span(input int i);
    return (acc_code[i] < 10) ? plen[i] + glen[i] + 1 : 2;
  endfunction

  function automatic bit exp_busy(input int i);
    return have[i] && ((n_edge - acc_edge[i]) < span(i) - 1);
  endfunction

  function automatic int unsigned exp_out(input int i);
    if (have[i] && acc_code[i] < 10 && (n_edge - acc_edge[i]) < plen[i])
      return 32'd1 << acc_code[i];
    return 0;
  endfunction

  function automatic bit exp_err(input int i);
    return have[i] && acc_code[i] >= 10 && (n_edge == acc_edge[i]);
  endfunction

  task automatic check_dut(input int i, input string nm, input logic [9:0] o,
                           input logic ov, input logic er, input logic [3:0] cq,
                           input logic bz, input logic rd);
    chk({nm, ".out"},       o,  exp_out(i));
    chk({nm, ".out_valid"}, ov, (exp_out(i) != 0) ? 1 : 0);
    chk({nm, ".err"},       er, exp_err(i));
    chk({nm, ".code_q"},    cq, have[i] ? acc_code[i] : 0);
    chk({nm, ".busy"},      bz, exp_busy(i));
    chk({nm, ".in_ready"},  rd, (!exp_busy(i) && !rst) ? 1 : 0);
    chk({nm, ".onehot"},    ($countones(o) <= 1) ? 1 : 0, 1);
  endtask

  // One clock cycle: check outputs at the falling edge, drive new inputs,
  // then advance the model at the rising edge.
  task automatic step(input bit r, input bit v, input int c);
    @(negedge clk);
    if (known) begin
      check_dut(0, "dut",      out0, ov0, err0, cq0, busy0, rdy0);
      check_dut(1, "dut_fast", out1, ov1, err1, cq1, busy1, rdy1);
    end
    rst      = r;
    in_valid = v;
    in_code  = 4'(c);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        have[i] = 1'b0;
      end else if (v && !exp_busy(i)) begin
        have[i]     = 1'b1;
        acc_edge[i] = n_edge + 1;
        acc_code[i] = c;
      end
    end
    if (r) known = 1'b1;
    n_edge++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    have = '{1'b0, 1'b0};
    // Reset, then release with in_valid low.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0);
    idle(2);
    // Single valid code 7.
    step(1'b0, 1'b1, 7);
    idle(6);
    // in_valid held high: code 0, then code 9 waiting for ready.
    step(1'b0, 1'b1, 0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 9);
    idle(7);
    // Invalid code 12, then code 3 offered straight away.
    step(1'b0, 1'b1, 12);
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 3);
    idle(7);
    // Boundary codes: highest legal line, lowest invalid code.
    step(1'b0, 1'b1, 9);
    idle(6);
    step(1'b0, 1'b1, 10);
    idle(2);
    // Reset during the second DRIVE cycle of code 5, then a fresh accept.
    step(1'b0, 1'b1, 5);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 5);
    idle(4);
    step(1'b0, 1'b1, 4);
    idle(7);
    // Stream 1,2,3 with each code held for two cycles.
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 1'b1, c);
      step(1'b0, 1'b1, c);
    end
    idle(7);
    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60,
           int'($urandom_range(0, 15)));
    end
    idle(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
